led_pwm_fader: RTL and testbench
================================

LED_PWM_FADER -- requirements
Module: led_pwm_fader

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 50000000, PL clock frequency in Hz (informational; used only in derived-rate comments and checks).
REQ-002 SHALL have parameter PRESCALE, default 8, CLK cycles per PWM tick (range 1..65535).
REQ-003 SHALL have parameter FADE_DIV, default 195312, CLK cycles per fade strobe (range 1..2^24).
REQ-004 SHALL have parameter FADE_STEP, default 32, level change per fade strobe (range 1..255).
REQ-005 SHALL have port CLK  input  1  PL clock.
REQ-006 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port LED_IN  input  4  target pattern from the upstream chaser; 1 means lit; synchronous to CLK.
REQ-008 SHALL have port EN  input  1  output enable; 0 blanks all outputs.
REQ-009 SHALL have port LED_OUT  output  4  PWM drive to LED4..LED1; 1 means on.
REQ-010 SHALL have port BUSY  output  1  high while any channel is RISE or FALL.

Function
REQ-011 SHALL run a prescaler (0..PRESCALE-1) that pulses tick for one CLK when it reaches PRESCALE-1, then wraps to 0.
REQ-012 SHALL run an 8-bit PWM counter that increments on each tick and wraps 255->0; period is 256*PRESCALE CLKs.
REQ-013 SHALL run a fade divider (0..FADE_DIV-1) that pulses strobe for one CLK when it reaches FADE_DIV-1, then wraps to 0.
REQ-014 SHALL keep, per channel, an 8-bit level and a 2-bit state: OFF, RISE, ON, FALL.
REQ-015 Transitions, evaluated every CLK: OFF and LED_IN=1 -> RISE; ON and LED_IN=0 -> FALL; RISE and LED_IN=0 -> FALL; FALL and LED_IN=1 -> RISE. A reversal keeps the current level.
REQ-016 On strobe in RISE, level SHALL become min(level+FADE_STEP, 255), computed 9-bit with saturation and no wrap; reaching 255 -> ON.
REQ-017 On strobe in FALL, level SHALL become max(level-FADE_STEP, 0) with saturation; reaching 0 -> OFF.
REQ-018 A direction change and a strobe in the same CLK SHALL step in the new direction.
REQ-019 Each channel SHALL copy level into a duty register only when the PWM counter is 0 and tick is high, so there are no mid-period glitches.
REQ-020 LED_OUT[i] SHALL be registered as EN & ((duty==255) | (pwm_cnt < duty)); duty 0 gives constant 0, and duty 255 gives constant 1.
REQ-021 LED_OUT SHALL reflect the counter and duty with exactly 1 CLK of latency.
REQ-022 EN=0 SHALL force LED_OUT=0 on the next CLK; levels, states and counters SHALL continue to update.
REQ-023 BUSY SHALL be combinational OR over channels of (state==RISE | state==FALL).

Reset
REQ-024 RST_N low SHALL asynchronously clear the prescaler, PWM counter, fade divider, all levels and all duty registers, set all states to OFF, and set LED_OUT=0 and BUSY=0.
REQ-025 Reset asserted mid-ramp SHALL abandon the ramp; after release, channels re-ramp from 0 toward LED_IN.
REQ-026 The first strobe after release SHALL occur FADE_DIV CLKs after the first rising CLK edge.

Structure
REQ-027 Shared package led_pkg SHALL hold the channel state encoding (OFF=0, RISE=1, ON=2, FALL=3), LEVEL_W=8, LEVEL_MAX=255 and NUM_LED=4.
REQ-028 A sub-module led_fade_channel (state, level, duty, compare output) SHALL be instantiated NUM_LED times. The prescaler, PWM counter and fade divider SHALL be shared in the top module.

Verification (PRESCALE=1, FADE_DIV=4, FADE_STEP=64)
REQ-029 Reset, then LED_IN=0001 held: ch0 level steps 0->64->128->192->255 on successive strobes; ch0 state ends ON; BUSY deasserts the CLK after level reaches 255; other channels remain at 0.
REQ-030 Ch0 at ON, then LED_IN=0000: level steps 255->191->127->63->0; state ends OFF; LED_OUT[0] stays 0 for a full period after duty reaches 0.
REQ-031 Ch0 in RISE at level 128, LED_IN drops to 0 coincident with a strobe: the next level is 64 and the state is FALL.
REQ-032 Duty=64 steady: LED_OUT[0] is high for exactly 64 of every 256 CLKs, and duty updates only at a PWM counter wrap.
REQ-033 EN pulsed low for 10 CLKs during ramps: LED_OUT=0000 for 10 CLKs, starting 1 CLK after EN falls, while level progression continues unchanged.
REQ-034 RST_N asserted asynchronously mid-ramp between CLK edges: LED_OUT and BUSY are 0 immediately, and all levels read 0 after release.

Source files
------------

// File: rtl/led_pkg.sv
// -----------------------------------------------------------------------------
// led_pkg
// Shared definitions for the LED PWM fader: the per-channel fade state
// encoding, the brightness level width/limit and the number of LED channels.
// -----------------------------------------------------------------------------
package led_pkg;

  localparam int LEVEL_W = 8;
  localparam int NUM_LED = 4;
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = 8'hFF;

  // Per-channel fade state.
  typedef enum logic [1:0] {
    CH_OFF  = 2'd0,
    CH_RISE = 2'd1,
    CH_ON   = 2'd2,
    CH_FALL = 2'd3
  } ch_state_t;

endpackage

// File: rtl/led_fade_channel.sv
// -----------------------------------------------------------------------------
// led_fade_channel
// One LED channel: fade FSM (OFF/RISE/ON/FALL), 8-bit brightness level,
// period-aligned duty register and the registered PWM compare output.
//
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   led_in     : target (1 = lit)
//   strobe     : one-cycle fade step pulse (shared)
//   load       : one-cycle pulse at PWM counter 0 with tick (shared)
//   pwm_cnt    : shared 8-bit PWM counter
//   en         : output enable
//   led_out    : registered PWM drive
//   state      : current fade state (also used by the top for BUSY)
// -----------------------------------------------------------------------------
module led_fade_channel
  import led_pkg::*;
#(
  parameter int FADE_STEP = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               led_in,
  input  logic               strobe,
  input  logic               load,
  input  logic [LEVEL_W-1:0] pwm_cnt,
  input  logic               en,
  output logic               led_out,
  output ch_state_t          state
);

  localparam logic [LEVEL_W-1:0] STEP8 = LEVEL_W'(FADE_STEP);
  localparam logic [LEVEL_W:0]   STEP9 = (LEVEL_W + 1)'(FADE_STEP);

  logic [LEVEL_W-1:0] level;
  logic [LEVEL_W-1:0] duty;
  ch_state_t          next_dir;
  logic [LEVEL_W:0]   up_sum;
  logic [LEVEL_W-1:0] up_level;
  logic [LEVEL_W-1:0] dn_level;

  // Direction for this cycle; a reversal keeps the current level, and a
  // strobe in the same cycle steps in the new direction.
  always_comb begin
    next_dir = state;
    case (state)
      CH_OFF:  if (led_in)  next_dir = CH_RISE;
      CH_ON:   if (!led_in) next_dir = CH_FALL;
      CH_RISE: if (!led_in) next_dir = CH_FALL;
      CH_FALL: if (led_in)  next_dir = CH_RISE;
      default: next_dir = CH_OFF;
    endcase
  end

  // 9-bit add so the carry flags saturation instead of wrapping.
  always_comb begin
    up_sum   = {1'b0, level} + STEP9;
    up_level = up_sum[LEVEL_W] ? LEVEL_MAX : up_sum[LEVEL_W-1:0];
    dn_level = (level > STEP8) ? (level - STEP8) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CH_OFF;
      level   <= '0;
      duty    <= '0;
      led_out <= 1'b0;
    end else begin
      state <= next_dir;
      if (strobe) begin
        if (next_dir == CH_RISE) begin
          level <= up_level;
          if (up_level == LEVEL_MAX) state <= CH_ON;
        end else if (next_dir == CH_FALL) begin
          level <= dn_level;
          if (dn_level == '0) state <= CH_OFF;
        end
      end
      // Duty only changes at the start of a PWM period: no mid-period glitch.
      if (load) duty <= level;
      // Full scale is forced on; otherwise compare gives duty/256 high time.
      led_out <= en & ((duty == LEVEL_MAX) | (pwm_cnt < duty));
    end
  end

endmodule

// File: rtl/led_pwm_fader.sv
// -----------------------------------------------------------------------------
// led_pwm_fader
// Four-channel LED fader: each LED fades toward its LED_IN target in steps of
// FADE_STEP every FADE_DIV clocks and is driven by an 8-bit PWM whose period
// is 256*PRESCALE clocks. With the defaults at 50 MHz the PWM runs at about
// 24.4 kHz and a full 0->255 ramp takes 8 strobes of ~3.9 ms.
//
// Ports
//   CLK     : clock
//   RST_N   : asynchronous active-low reset
//   LED_IN  : 4-bit target pattern (1 = lit)
//   EN      : output enable, 0 blanks LED_OUT on the next clock
//   LED_OUT : 4-bit PWM drive (1 = on)
//   BUSY    : high while any channel is ramping
// -----------------------------------------------------------------------------
module led_pwm_fader
  import led_pkg::*;
#(
  parameter int CLOCK_FREQ = 50000000,
  parameter int PRESCALE   = 8,
  parameter int FADE_DIV   = 195312,
  parameter int FADE_STEP  = 32
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [NUM_LED-1:0] LED_IN,
  input  logic               EN,
  output logic [NUM_LED-1:0] LED_OUT,
  output logic               BUSY
);

  if (CLOCK_FREQ < 1 || PRESCALE < 1 || PRESCALE > 65535 ||
      FADE_DIV < 1 || FADE_DIV > (1 << 24) ||
      FADE_STEP < 1 || FADE_STEP > 255) begin : g_param_check
    $error("led_pwm_fader: parameter out of range");
  end

  localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);
  localparam logic [24:0] DIV_LAST   = 25'(FADE_DIV - 1);

  logic [15:0]        presc;
  logic [LEVEL_W-1:0] pwm_cnt;
  logic [24:0]        div_cnt;
  logic               tick;
  logic               strobe;
  logic               load;
  ch_state_t          ch_state [NUM_LED];
  logic [NUM_LED-1:0] ch_busy;

  assign tick   = (presc == PRESC_LAST);
  assign strobe = (div_cnt == DIV_LAST);
  assign load   = tick & (pwm_cnt == '0);

  // Shared timebase: prescaler, PWM counter (wraps 255->0), fade divider.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      presc   <= '0;
      pwm_cnt <= '0;
      div_cnt <= '0;
    end else begin
      presc   <= tick ? '0 : presc + 16'd1;
      if (tick) pwm_cnt <= pwm_cnt + 8'd1;
      div_cnt <= strobe ? '0 : div_cnt + 25'd1;
    end
  end

  for (genvar i = 0; i < NUM_LED; i++) begin : g_ch
    led_fade_channel #(
      .FADE_STEP (FADE_STEP)
    ) u_ch (
      .clk     (CLK),
      .rst_n   (RST_N),
      .led_in  (LED_IN[i]),
      .strobe  (strobe),
      .load    (load),
      .pwm_cnt (pwm_cnt),
      .en      (EN),
      .led_out (LED_OUT[i]),
      .state   (ch_state[i])
    );
    assign ch_busy[i] = (ch_state[i] == CH_RISE) | (ch_state[i] == CH_FALL);
  end

  assign BUSY = |ch_busy;

endmodule

// File: tb/tb_led_pwm_fader.sv
// -----------------------------------------------------------------------------
// tb_led_pwm_fader
// Self-checking bench: directed fade scenarios plus random LED_IN/EN traffic,
// compared every cycle against a behavioural model of levels, duty and PWM.
// -----------------------------------------------------------------------------
module tb_led_pwm_fader;

  localparam int P_PRESCALE = 1;
  localparam int P_FADE_DIV = 4;
  localparam int P_STEP     = 64;

  // Model direction codes (bench-local).
  localparam int M_OFF = 0, M_UP = 1, M_FULL = 2, M_DOWN = 3;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] led_in;
  logic [3:0] led_out;
  logic       busy;

  always #5 clk = ~clk;

  led_pwm_fader #(
    .CLOCK_FREQ (50000000),
    .PRESCALE   (P_PRESCALE),
    .FADE_DIV   (P_FADE_DIV),
    .FADE_STEP  (P_STEP)
  ) dut (
    .CLK     (clk),
    .RST_N   (rst_n),
    .LED_IN  (led_in),
    .EN      (en),
    .LED_OUT (led_out),
    .BUSY    (busy)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, expv, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int   m_presc, m_pwm, m_div;
  int   m_lvl  [4];
  int   m_mode [4];
  int   m_duty [4];
  logic [3:0] m_out;

  function automatic void model_reset();
    m_presc = 0; m_pwm = 0; m_div = 0; m_out = '0;
    for (int i = 0; i < 4; i++) begin
      m_lvl[i] = 0; m_mode[i] = M_OFF; m_duty[i] = 0;
    end
  endfunction

  function automatic logic model_busy();
    logic b = 1'b0;
    for (int i = 0; i < 4; i++)
      if (m_mode[i] == M_UP || m_mode[i] == M_DOWN) b = 1'b1;
    return b;
  endfunction

  // One rising edge of the model, using the inputs applied before the edge.
  function automatic void model_edge();
    bit tick   = (m_presc == P_PRESCALE - 1);
    bit strobe = (m_div == P_FADE_DIV - 1);
    for (int i = 0; i < 4; i++) begin
      m_out[i] = en && (m_duty[i] == 255 || m_pwm < m_duty[i]);
      if (tick && m_pwm == 0) m_duty[i] = m_lvl[i];
      if (led_in[i] && (m_mode[i] == M_OFF || m_mode[i] == M_DOWN)) m_mode[i] = M_UP;
      if (!led_in[i] && (m_mode[i] == M_FULL || m_mode[i] == M_UP)) m_mode[i] = M_DOWN;
      if (strobe && m_mode[i] == M_UP) begin
        m_lvl[i] = (m_lvl[i] + P_STEP > 255) ? 255 : m_lvl[i] + P_STEP;
        if (m_lvl[i] == 255) m_mode[i] = M_FULL;
      end else if (strobe && m_mode[i] == M_DOWN) begin
        m_lvl[i] = (m_lvl[i] - P_STEP < 0) ? 0 : m_lvl[i] - P_STEP;
        if (m_lvl[i] == 0) m_mode[i] = M_OFF;
      end
    end
    m_presc = tick ? 0 : m_presc + 1;
    if (tick) m_pwm = (m_pwm + 1) % 256;
    m_div = strobe ? 0 : m_div + 1;
  endfunction

  // ---------------- driver tasks ----------------
  // Inputs change only at the falling edge; outputs are checked there too.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    exp_q.push_back({27'd0, model_busy(), m_out});
    check_val("led_out", {28'd0, led_out}, {28'd0, exp_q[0][3:0]});
    check_val("busy", {31'd0, busy}, {31'd0, exp_q[0][4]});
    void'(exp_q.pop_front());
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_val("rst_led_out", {28'd0, led_out}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit found;
    rst_n  = 1'b0;
    en     = 1'b1;
    led_in = 4'b0000;
    model_reset();
    #1;
    check_val("por_led_out", {28'd0, led_out}, 32'd0);
    check_val("por_busy", {31'd0, busy}, 32'd0);
    do_reset();

    // Ramp ch0 up to full, hold a few periods, then ramp down.
    led_in = 4'b0001;
    run(600);
    led_in = 4'b0000;
    run(600);

    // Reverse ch0 while rising at level 128, on the same cycle as a strobe.
    led_in = 4'b0001;
    found  = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      if (m_mode[0] == M_UP && m_lvl[0] == 128 && m_div == P_FADE_DIV - 1) begin
        found  = 1'b1;
        led_in = 4'b0000;
      end
      cycle();
    end
    check_val("reverse_aligned", {31'd0, found}, 32'd1);
    run(300);

    // EN blanked for 10 cycles with ramps in flight.
    led_in = 4'b1111;
    run(6);
    en = 1'b0;
    run(10);
    en = 1'b1;
    run(600);

    // Asynchronous reset between clock edges in the middle of a ramp.
    led_in = 4'b0101;
    do_reset();
    led_in = 4'b1111;
    run(600);
    led_in = 4'b0110;
    run(7);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_val("async_led_out", {28'd0, led_out}, 32'd0);
    check_val("async_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run(600);

    // Random traffic on LED_IN and EN.
    for (int k = 0; k < 20000; k++) begin
      if ($urandom_range(0, 7) == 0)  led_in = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 63) == 0) en = ~en;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
